// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - op codes, FSM states and op helpers for universal_shift_reg
package usr_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_SHL   = 3'd2;
  localparam logic [2:0] OP_SHR   = 3'd3;
  localparam logic [2:0] OP_ROL   = 3'd4;
  localparam logic [2:0] OP_ROR   = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Shift/rotate ops are the only ones that take a count.
  function automatic logic is_step_op(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/usr_step.sv
// rtl/usr_step.sv - one-bit shift/rotate next-value function
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic             serial_in_l,
  input  logic             serial_in_r,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      OP_SHL:  q_next = {q[WIDTH-2:0], serial_in_r};
      OP_SHR:  q_next = {serial_in_l, q[WIDTH-1:1]};
      OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - width-generic load/clear/shift/rotate register, one bit per cycle
// Optional abort input/aborted pulse when USR_ABORT_EN is defined.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in_l,
  input  logic             serial_in_r,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out_l,
  output logic             serial_out_r,
  output logic             busy,
  output logic             done
`ifdef USR_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_val;
  logic             abort_req;

`ifdef USR_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort_req = abort;
  assign aborted   = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  // The accept edge steps with the incoming op; later edges use the latched one.
  assign step_op = (state_q == ST_RUN) ? op_q : cmd_op;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .q           (data_q),
    .op          (step_op),
    .serial_in_l (serial_in_l),
    .serial_in_r (serial_in_r),
    .q_next      (step_val)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef USR_ABORT_EN
    aborted_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          if (cmd_op == OP_LOAD) begin
            data_d = parallel_in;
            done_d = 1'b1;
          end else if (cmd_op == OP_CLEAR) begin
            data_d = '0;
            done_d = 1'b1;
          end else if (is_step_op(cmd_op) && (cmd_amt != '0)) begin
            data_d = step_val;
            if (cmd_amt == AMT_W'(1)) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_RUN;
              count_d = cmd_amt - AMT_W'(1);
            end
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort_req) begin
          state_d = ST_IDLE;
          count_d = '0;
`ifdef USR_ABORT_EN
          aborted_d = 1'b1;
`endif
        end else begin
          data_d  = step_val;
          count_d = count_q - AMT_W'(1);
          if (count_q == AMT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      op_q    <= OP_NOP;
      data_q  <= '0;
      done_q  <= 1'b0;
`ifdef USR_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      data_q  <= data_d;
      done_q  <= done_d;
`ifdef USR_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q == ST_RUN);
  assign done         = done_q;
  assign parallel_out = data_q;
  assign serial_out_l = data_q[WIDTH-1];
  assign serial_out_r = data_q[0];

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised successor to the fixed 4-bit parallel-in/parallel-out register. Adds parameterised width, a command interface with a valid/ready handshake, and operations for load, clear, shift and rotate. Multi-bit shifts execute one bit per cycle under a small FSM. Used wherever a datapath needs a width-generic holding, serialising or alignment register.

Parameters:
- WIDTH, 8: data register width, ≥2.
- AMT_W, $clog2(WIDTH)+1: width of the shift-amount field, so amounts 0..WIDTH (and above) are representable.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-low reset. rst=0 resets immediately, independent of clk.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: block can accept a command; equals state==IDLE.
- cmd_op, input, 3: operation code (encoding in Behaviour).
- cmd_amt, input, AMT_W: shift/rotate count.
- parallel_in, input, WIDTH: LOAD data.
- serial_in_l, input, 1: bit entering the MSB on SHR.
- serial_in_r, input, 1: bit entering the LSB on SHL.
- parallel_out, output, WIDTH: register contents.
- serial_out_l, output, 1: parallel_out[WIDTH-1].
- serial_out_r, output, 1: parallel_out[0].
- busy, output, 1: equals state==RUN.
- done, output, 1: one-cycle completion pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - parallel_out=0, state=IDLE, count=0, done=0.
  - Outputs therefore show cmd_ready=1 and busy=0.
  - Reset asserted mid-RUN aborts the operation; no done pulse is generated.
- Op encoding:
  - 0 NOP, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 CLEAR.
  - 7 is reserved and is treated as NOP.
- Single-bit step definitions:
  - SHL: {q[W-2:0], serial_in_r}.
  - SHR: {serial_in_l, q[W-1:1]}.
  - ROL: {q[W-2:0], q[W-1]}.
  - ROR: {q[0], q[W-1:1]}.
  - Serial inputs are sampled on every step edge.
- Accept: a command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
- Single-edge completions (FSM stays in IDLE; done=1 in the following cycle):
  - NOP, or reserved op 7.
  - LOAD: parallel_out<=parallel_in.
  - CLEAR: parallel_out<=0.
  - Any shift/rotate with cmd_amt=0: register unchanged.
- Shift/rotate with amt=N≥1:
  - Step 1 is applied at the accept edge.
  - If N=1: stay IDLE; done pulses next cycle.
  - If N>1: go to RUN with count=N-1.
  - In RUN, each edge applies one step and decrements count. At the edge where count reaches 0, return to IDLE; done pulses in the next cycle.
  - Total: N edges; busy high N-1 cycles; done in cycle N after accept.
- Command latching: op and amt are latched at accept. cmd_* inputs are ignored while busy.
- done and a new accept may coincide, i.e. back-to-back commands with zero bubble.
- Amounts greater than WIDTH are legal: shifts saturate the contents to serial fill, rotates wrap modulo WIDTH naturally.
- Combinational outputs: cmd_ready and busy are decoded from the state register; serial_out_* are taps of parallel_out.

Optional Feature:
- Macro: USR_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit, one-cycle pulse).
  - abort=1 in RUN: the next edge applies no step, returns to IDLE and clears count; aborted=1 the following cycle; no done pulse.
  - abort takes priority over a scheduled step.
  - abort in IDLE is ignored.
- Undefined: the ports do not exist; a RUN always runs to completion.

Decomposition:
- Package usr_pkg holds:
  - op encodings as localparam constants (OP_NOP..OP_CLEAR).
  - FSM state encodings (ST_IDLE, ST_RUN).
- Sub-module usr_step: combinational next-value function taking (q, op, serial_in_l, serial_in_r) and returning the one-step result.
- The top module holds the FSM, count and the register.

Test Plan (WIDTH=8):
- LOAD 0xA5 → parallel_out=0xA5 after the accept edge; done high exactly one cycle; busy never high.
- From 0xA5, SHL amt=3, serial_in_r=1 → values 0x4B, 0x97, 0x2F on consecutive edges; busy for 2 cycles; done in cycle 3; serial_out_l=0 at the end.
- From 0x3C, ROR amt=8 → cmd_ready low for 7 cycles, final value 0x3C, a single done pulse. Then amt=0 → immediate done with the value unchanged.
- cmd_valid held with LOAD 0xFF during a busy SHR → accepted only on the first cycle cmd_ready=1; parallel_out=0xFF one edge later, with no lost or duplicate done.
- rst driven low mid-RUN (asynchronously, between clock edges) → parallel_out=0 and cmd_ready=1 without waiting for a clock edge; no done pulse after release.
- USR_ABORT_EN: from 0xF0, SHR amt=5, serial_in_l=0, abort after 2 steps → value held at 0x3C; aborted pulses once; done never asserts.
